// File: rtl/ones_pattern_gen_if.sv
// Start/done handshake and result bus shared by the thermometer-word generator
// and whoever drives it (a controller or a testbench).
interface ones_pattern_gen_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
);
    logic             s;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output s, count,
        input  data, busy, done, ovf
    );

    modport slave (
        input  s, count,
        output data, busy, done, ovf
    );
endinterface

// File: rtl/ones_pattern_gen.sv
// Serial thermometer-word builder: on start it shifts in min(count,WIDTH) ones
// from the LSB end, one per clock, and then holds the word with done high.
module ones_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int CW    = 4
) (
    input  logic                clk,
    input  logic                reset,
    ones_pattern_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [CW-1:0] WIDTH_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] ONE_CNT   = CW'(1);

    state_t           state, state_next;
    logic [WIDTH-1:0] data, data_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic             ovf, ovf_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            data  <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            data  <= data_next;
            cnt   <= cnt_next;
            ovf   <= ovf_next;
        end
    end

    // count is only looked at in S_IDLE; oversize requests clamp to WIDTH and flag ovf.
    always_comb begin
        state_next = state;
        data_next  = data;
        cnt_next   = cnt;
        ovf_next   = ovf;
        unique case (state)
            S_IDLE: begin
                if (bus.s) begin
                    state_next = S_BUILD;
                    data_next  = '0;
                    if (bus.count > WIDTH_CNT) begin
                        cnt_next = WIDTH_CNT;
                        ovf_next = 1'b1;
                    end else begin
                        cnt_next = bus.count;
                        ovf_next = 1'b0;
                    end
                end
            end
            S_BUILD: begin
                if (cnt != '0) begin
                    data_next = {data[WIDTH-2:0], 1'b1};
                    cnt_next  = cnt - ONE_CNT;
                end else begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.s) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus.data = data;
    assign bus.ovf  = ovf;
    assign bus.busy = (state == S_BUILD);
    assign bus.done = (state == S_DONE);

endmodule
